trsq8_intc: RTL and testbench
=============================

# trsq8_intc

Interrupt controller sitting directly upstream of the TRSQ8 core's `irq` input. Collects up to eight external interrupt sources, synchronises and rising-edge-detects them, latches them as pending, applies a software mask and fixed priority, and drives a single level `irq` to the core. It tracks the in-service source through an acknowledge / end-of-interrupt handshake and exposes mask, pending and vector state on a small register port for the core's I/O space.

## Interface
Parameters:
- `N_SRC`, 4: number of interrupt sources, 1..8; register bits at index ≥ N_SRC read 0 and ignore writes.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset; clears all state.
- `src`  in  N_SRC  raw interrupt requests, asynchronous to `clk`; rising edge = request.
- `irq`  out  1  interrupt request to core, registered, level.
- `ack`  in  1  one-cycle pulse from core on interrupt entry.
- `eoi`  in  1  one-cycle pulse from core on return from ISR.
- `wr_en`  in  1  register write strobe.
- `addr`  in  2  register address.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, combinational from `addr`.

## Operation
- Input path: per source, 2-flop synchroniser (`s1`, `s2`) plus history flop `s3`; `edge = s2 & ~s3`.
- Pending register `pend[N_SRC-1:0]`:
  - set by `edge`, by a write to SWINT, or (no clear) …
  - cleared by W1C write to PENDING or by `ack` for the selected source.
  - Set has priority over clear in the same cycle.
- `active = pend & mask`. Highest priority is the lowest index.
- Registers:
  - addr 0, MASK: rw, reset 0x00; 1 = enabled.
  - addr 1, PENDING: read `pend`; write 1 clears bits.
  - addr 2, VECTOR: read {`insvc`, 4'b0, `vec[2:0]`}; writes ignored.
  - addr 3, SWINT: write 1 sets pending bits; reads 0x00.
- FSM, with states IDLE, REQ and SERVICE:
  - IDLE: if `active != 0`, go to REQ and latch `vec` = index of the highest-priority active bit.
  - REQ: `irq` = 1.
    - `vec` re-tracks the highest-priority active bit each cycle, so a higher-priority arrival preempts the selection before `ack`.
    - If `active` becomes 0 (mask or W1C), return to IDLE.
    - On `ack`: clear `pend[vec]`, set `insvc`, go to SERVICE.
  - SERVICE: `irq` = 0 and `vec` is frozen. No nesting. On `eoi`, clear `insvc` and go to IDLE.
- `ack` outside REQ and `eoi` outside SERVICE are ignored.
- Reset mid-operation: FSM goes to IDLE. `pend`, `mask`, `vec`, `insvc`, sync flops and `irq` all clear immediately, with no dependence on `clk`.

## Timing
- Reset values: `irq` = 0; `rdata` reflects cleared registers (0x00 at every address).
- `src` rising before edge k:
  - `s1` = 1 at k, `s2` = 1 at k+1.
  - `pend` set at k+2.
  - FSM enters REQ and `irq` = 1 at k+3 (if masked in).
  - End-to-end latency: 3 cycles.
- A source held high produces one pending event. It must go low for at least 2 cycles before it can re-trigger.
- SWINT write at edge k: `pend` set at k, `irq` = 1 at k+1.
- MASK write enabling an already-pending bit at edge k: `irq` = 1 at k+1.
- `ack` sampled at edge k: `irq` = 0, `pend[vec]` = 0 and `insvc` = 1, all visible after k.
- `eoi` at edge k: IDLE after k. If another source is active, `irq` = 1 at k+1.
- Simultaneous `ack` and a new edge on the same source: bit stays pending. `irq` re-asserts 1 cycle after the following `eoi`.
- Simultaneous W1C and edge on the same bit: bit stays set.
- Register writes take effect at the clock edge where `wr_en` = 1.

## Test plan
- Reset: assert `reset` mid-SERVICE with `pend` = 0x3. Expect `irq` = 0 and all reads 0x00 immediately. After release, idle `src` produces no `irq`.
- Basic: MASK = 0x0F; pulse `src[2]` high at edge 10.
  - Expect `irq` = 1 from cycle 13 and VECTOR = 0x02.
  - `ack` at 15 → `irq` = 0, VECTOR = 0x82, PENDING = 0x00.
  - `eoi` at 20 → VECTOR = 0x02, `irq` stays 0.
- Priority/preempt: MASK = 0x0F; `src[3]` then, 1 cycle later, `src[0]`.
  - Before `ack`, VECTOR = 0x00.
  - After `ack`, PENDING = 0x08.
  - After `eoi`, `irq` re-asserts next cycle with VECTOR = 0x03.
- Masking: MASK = 0x00 and `src[1]` pulses → PENDING = 0x02, `irq` = 0. Write MASK = 0x02 → `irq` = 1 next cycle. Write MASK = 0x00 while in REQ → `irq` = 0 next cycle.
- SWINT/W1C: write SWINT = 0x05 → PENDING = 0x05. Write PENDING = 0x04 in the same cycle as an `src[2]` edge → PENDING stays 0x05.
- Held source: `src[1]` held high for 50 cycles → exactly one pending event. `ack` + `eoi` → `irq` stays 0.

Source files
------------

// File: rtl/trsq8_intc.sv
// Interrupt controller for the TRSQ8 core: synchronised edge-detected sources,
// mask and fixed priority, ack/eoi service tracking and a 4-register I/O port.
module trsq8_intc #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src,
    output logic             irq,
    input  logic             ack,
    input  logic             eoi,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    // Bits at or above N_SRC are held at zero so they read 0 and ignore writes.
    localparam logic [7:0] VALID = 8'((9'd1 << N_SRC) - 9'd1);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state;
    logic [7:0] src_ext;
    logic [7:0] s1, s2, s3;
    logic [7:0] rise;
    logic [7:0] pend;
    logic [7:0] mask;
    logic [7:0] active;
    logic [7:0] set_bits;
    logic [7:0] clr_bits;
    logic [2:0] vec;
    logic       insvc;
    logic       take_ack;

    function automatic logic [2:0] prio(input logic [7:0] a);
        prio = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (a[i]) prio = 3'(i);
        end
    endfunction

    assign src_ext  = 8'(src);
    assign rise     = s2 & ~s3;
    assign active   = pend & mask;
    assign take_ack = (state == REQ) && ack && (active != 8'h00);
    assign set_bits = rise | ((wr_en && addr == 2'd3) ? wdata : 8'h00);
    assign clr_bits = ((wr_en && addr == 2'd1) ? wdata : 8'h00)
                    | (take_ack ? (8'h01 << vec) : 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 8'h00;
            s2 <= 8'h00;
            s3 <= 8'h00;
        end else begin
            s1 <= src_ext;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Set wins over clear so an edge coinciding with W1C or ack is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 8'h00;
            mask <= 8'h00;
        end else begin
            pend <= ((pend & ~clr_bits) | set_bits) & VALID;
            if (wr_en && addr == 2'd0) mask <= wdata & VALID;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            irq   <= 1'b0;
            vec   <= 3'd0;
            insvc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (active != 8'h00) begin
                        state <= REQ;
                        irq   <= 1'b1;
                        vec   <= prio(active);
                    end
                end
                REQ: begin
                    if (active == 8'h00) begin
                        state <= IDLE;
                        irq   <= 1'b0;
                    end else if (ack) begin
                        state <= SERVICE;
                        irq   <= 1'b0;
                        insvc <= 1'b1;
                    end else begin
                        vec <= prio(active);
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        state <= IDLE;
                        insvc <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    irq   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (addr)
            2'd0: rdata = mask;
            2'd1: rdata = pend;
            2'd2: rdata = {insvc, 4'b0000, vec};
            default: rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_trsq8_intc.sv
// Scenario bench for trsq8_intc: expected values are queued as stimulus is
// driven and popped when the DUT response is sampled.
module tb_trsq8_intc;

    logic       clk;
    logic       reset;
    logic [3:0] src;
    logic       irq;
    logic       ack;
    logic       eoi;
    logic       wr_en;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    int checks = 0;
    int passed = 0;
    logic [7:0] sb[$];

    trsq8_intc #(.N_SRC(4)) dut (
        .clk(clk), .reset(reset), .src(src), .irq(irq), .ack(ack), .eoi(eoi),
        .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        addr = a; wdata = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic pulse_ack;
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic pulse_eoi;
        eoi = 1'b1; tick(); eoi = 1'b0;
    endtask

    task automatic test_reset;
        logic [7:0] got, exp;
        reset = 1'b1;
        #2;
        repeat (5) sb.push_back(8'h00);
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL reset_irq: got %02h expected %02h", got, exp); else passed++;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), got); exp = sb.pop_front(); checks++;
            if (got !== exp) $display("[TB] FAIL reset_reg%0d: got %02h expected %02h", a, got, exp); else passed++;
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        logic [7:0] got, exp;
        wr(2'd0, 8'h0F);
        src = 4'b0100;
        tick();
        src = 4'b0000;
        sb.push_back(8'h00); sb.push_back(8'h04); sb.push_back(8'h01); sb.push_back(8'h02);
        sb.push_back(8'h00); sb.push_back(8'h82); sb.push_back(8'h00);
        sb.push_back(8'h02); sb.push_back(8'h00);
        tick(); tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_irq_early: got %02h expected %02h", got, exp); else passed++;
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_pend: got %02h expected %02h", got, exp); else passed++;
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_irq: got %02h expected %02h", got, exp); else passed++;
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_vec: got %02h expected %02h", got, exp); else passed++;
        tick();
        pulse_ack();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_ack_irq: got %02h expected %02h", got, exp); else passed++;
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_ack_vec: got %02h expected %02h", got, exp); else passed++;
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_ack_pend: got %02h expected %02h", got, exp); else passed++;
        repeat (4) tick();
        pulse_eoi();
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_eoi_vec: got %02h expected %02h", got, exp); else passed++;
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL basic_eoi_irq: got %02h expected %02h", got, exp); else passed++;
    endtask

    task automatic test_preempt;
        logic [7:0] got, exp;
        wr(2'd0, 8'h0F);
        src = 4'b1000; tick();
        src = 4'b0001; tick();
        src = 4'b0000;
        sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'h08);
        sb.push_back(8'h80); sb.push_back(8'h00); sb.push_back(8'h01); sb.push_back(8'h03);
        tick(); tick(); tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_irq: got %02h expected %02h", got, exp); else passed++;
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_vec: got %02h expected %02h", got, exp); else passed++;
        pulse_ack();
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_pend: got %02h expected %02h", got, exp); else passed++;
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_insvc: got %02h expected %02h", got, exp); else passed++;
        tick();
        pulse_eoi();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_eoi_irq0: got %02h expected %02h", got, exp); else passed++;
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_reassert: got %02h expected %02h", got, exp); else passed++;
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL preempt_vec3: got %02h expected %02h", got, exp); else passed++;
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_masking;
        logic [7:0] got, exp;
        wr(2'd0, 8'h00);
        src = 4'b0010; tick();
        src = 4'b0000;
        sb.push_back(8'h02); sb.push_back(8'h00); sb.push_back(8'h01);
        sb.push_back(8'h01); sb.push_back(8'h00);
        repeat (4) tick();
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL mask_pend: got %02h expected %02h", got, exp); else passed++;
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL mask_irq_off: got %02h expected %02h", got, exp); else passed++;
        wr(2'd0, 8'h02);
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL mask_enable_irq: got %02h expected %02h", got, exp); else passed++;
        wr(2'd0, 8'h00);
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL mask_disable_same: got %02h expected %02h", got, exp); else passed++;
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL mask_disable_irq: got %02h expected %02h", got, exp); else passed++;
        wr(2'd1, 8'h02);
    endtask

    task automatic test_swint_w1c;
        logic [7:0] got, exp;
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h05);
        sb.push_back(8'h05); sb.push_back(8'h05); sb.push_back(8'h01);
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL swint_pend: got %02h expected %02h", got, exp); else passed++;
        src = 4'b0100;
        tick(); tick();
        wr(2'd1, 8'h04);
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL w1c_vs_edge: got %02h expected %02h", got, exp); else passed++;
        src = 4'b0000;
        wr(2'd1, 8'h04);
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL w1c_clear: got %02h expected %02h", got, exp); else passed++;
        wr(2'd1, 8'h01);
    endtask

    task automatic test_ack_edge;
        logic [7:0] got, exp;
        wr(2'd0, 8'h01);
        src = 4'b0001; addr = 2'd3; wdata = 8'h01; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'h01);
        sb.push_back(8'h80); sb.push_back(8'h00); sb.push_back(8'h01);
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL ackedge_req: got %02h expected %02h", got, exp); else passed++;
        pulse_ack();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL ackedge_irq: got %02h expected %02h", got, exp); else passed++;
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL ackedge_pend: got %02h expected %02h", got, exp); else passed++;
        rd(2'd2, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL ackedge_vec: got %02h expected %02h", got, exp); else passed++;
        src = 4'b0000;
        repeat (3) tick();
        pulse_eoi();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL ackedge_eoi: got %02h expected %02h", got, exp); else passed++;
        tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL ackedge_reassert: got %02h expected %02h", got, exp); else passed++;
        pulse_ack();
        pulse_eoi();
    endtask

    task automatic test_held;
        logic [7:0] got, exp;
        int waited;
        wr(2'd0, 8'h02);
        src = 4'b0010;
        sb.push_back(8'h01); sb.push_back(8'h00); sb.push_back(8'h00);
        waited = 0;
        while (irq !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL held_irq: got %02h expected %02h", got, exp); else passed++;
        pulse_ack();
        repeat (40) tick();
        pulse_eoi();
        repeat (4) tick();
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL held_no_retrigger: got %02h expected %02h", got, exp); else passed++;
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL held_pend: got %02h expected %02h", got, exp); else passed++;
        src = 4'b0000;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid;
        logic [7:0] got, exp;
        logic seen;
        wr(2'd0, 8'h0F);
        wr(2'd3, 8'h04);
        tick();
        pulse_ack();
        wr(2'd3, 8'h03);
        sb.push_back(8'h03);
        repeat (5) sb.push_back(8'h00);
        sb.push_back(8'h00);
        rd(2'd1, got); exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL rstmid_pre_pend: got %02h expected %02h", got, exp); else passed++;
        reset = 1'b1;
        #1;
        got = {7'b0, irq}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL rstmid_irq: got %02h expected %02h", got, exp); else passed++;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), got); exp = sb.pop_front(); checks++;
            if (got !== exp) $display("[TB] FAIL rstmid_reg%0d: got %02h expected %02h", a, got, exp); else passed++;
        end
        tick();
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (irq !== 1'b0) seen = 1'b1;
        end
        got = {7'b0, seen}; exp = sb.pop_front(); checks++;
        if (got !== exp) $display("[TB] FAIL rstmid_idle_irq: got %02h expected %02h", got, exp); else passed++;
    endtask

    initial begin
        reset = 1'b1; src = 4'b0000; ack = 1'b0; eoi = 1'b0;
        wr_en = 1'b0; addr = 2'd0; wdata = 8'h00;
        test_reset();
        test_basic();
        test_preempt();
        test_masking();
        test_swint_w1c();
        test_ack_edge();
        test_held();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
